// File: rtl/delay_timer_ctrl_if.sv
// Serial-command / status bundle for the delay timer controller.
// The master drives the bit stream and acknowledge; the slave reports timer status.
interface delay_timer_ctrl_if;
  logic       data;
  logic       ack;
  logic [3:0] count;
  logic       counting;
  logic       done;

  modport master (output data, output ack, input count, input counting, input done);
  modport slave  (input data, input ack, output count, output counting, output done);
endinterface

// File: rtl/delay_timer_ctrl.sv
// Detects 1101 on a serial stream, loads a 4-bit delay MSB first, then counts
// (delay+1)*TICKS cycles and holds done until acknowledged.
module delay_timer_ctrl #(
  parameter int TICKS = 1000
) (
  input logic               clk,
  input logic               reset,
  delay_timer_ctrl_if.slave bus
);

  localparam int TW = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS - 1);

  typedef enum logic [3:0] {
    SRCH, SRCH1, SRCH11, SRCH110,
    LOAD0, LOAD1, LOAD2, LOAD3,
    COUNT, WAIT
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [3:0]      delay;
  logic [3:0]      remaining;
  logic [TW-1:0]   tick;
  logic            last_tick;

  assign last_tick = (tick == TICK_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= SRCH;
    else       state <= next_state;
  end

  // Unused encodings fall through to the default and recover to SRCH.
  always_comb begin
    next_state = SRCH;
    case (state)
      SRCH:    next_state = bus.data ? SRCH1   : SRCH;
      SRCH1:   next_state = bus.data ? SRCH11  : SRCH;
      SRCH11:  next_state = bus.data ? SRCH11  : SRCH110;
      SRCH110: next_state = bus.data ? LOAD0   : SRCH;
      LOAD0:   next_state = LOAD1;
      LOAD1:   next_state = LOAD2;
      LOAD2:   next_state = LOAD3;
      LOAD3:   next_state = COUNT;
      COUNT:   next_state = (last_tick && remaining == 4'd0) ? WAIT : COUNT;
      WAIT:    next_state = bus.ack ? SRCH : WAIT;
      default: next_state = SRCH;
    endcase
  end

  // The final LOAD bit goes straight into the countdown so COUNT starts with d.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay     <= 4'd0;
      remaining <= 4'd0;
      tick      <= '0;
    end else begin
      case (state)
        LOAD0, LOAD1, LOAD2: begin
          delay <= {delay[2:0], bus.data};
          tick  <= '0;
        end
        LOAD3: begin
          delay     <= {delay[2:0], bus.data};
          remaining <= {delay[2:0], bus.data};
          tick      <= '0;
        end
        COUNT: begin
          if (last_tick) begin
            tick <= '0;
            if (remaining != 4'd0) remaining <= remaining - 4'd1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: tick <= '0;
      endcase
    end
  end

  always_comb begin
    bus.counting = (state == COUNT);
    bus.done     = (state == WAIT);
    bus.count    = (state == COUNT) ? remaining : 4'd0;
  end

endmodule

// File: tb/tb_delay_timer_ctrl.sv
// Directed bench for delay_timer_ctrl: a vector table for the basic flow plus
// hand-written multi-cycle sequences (TICKS=4 instance and a default-TICKS instance).
module tb_delay_timer_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  delay_timer_ctrl_if bus_a ();
  delay_timer_ctrl_if bus_b ();

  delay_timer_ctrl #(.TICKS(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  delay_timer_ctrl dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       data;
    logic       ack;
    logic       exp_counting;
    logic       exp_done;
    logic [3:0] exp_count;
  } vec_t;

  vec_t vq[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic exp_c, input logic exp_d,
                              input logic [3:0] exp_n);
    n_compared++;
    if (bus_a.counting !== exp_c || bus_a.done !== exp_d || bus_a.count !== exp_n) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got counting=%b done=%b count=%0d, expected counting=%b done=%b count=%0d",
               name, bus_a.counting, bus_a.done, bus_a.count, exp_c, exp_d, exp_n);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset      = v.rst;
    bus_a.data = v.data;
    bus_a.ack  = v.ack;
    step();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus_a.data = bits[i];
      step();
    end
    bus_a.data = 1'b0;
  endtask

  // Expects the first COUNT cycle to be visible on entry; leaves the DUT in WAIT.
  task automatic run_profile(input int d, input bit disturb);
    for (int k = 0; k < (d + 1) * 4; k++) begin
      check_output($sformatf("profile d=%0d k=%0d", d, k), 1'b1, 1'b0, 4'(d - k / 4));
      if (disturb) begin
        bus_a.data = 1'($urandom_range(0, 1));
        bus_a.ack  = 1'(k % 2);
      end
      step();
    end
    bus_a.data = 1'b0;
    bus_a.ack  = 1'b0;
    check_output($sformatf("expiry d=%0d", d), 1'b0, 1'b1, 4'd0);
  endtask

  task automatic ack_pulse();
    bus_a.ack = 1'b1;
    step();
    bus_a.ack = 1'b0;
    check_output("ack_clear", 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    int cycles;
    int ones;
    int first_count;

    bus_a.data = 1'b0;
    bus_a.ack  = 1'b0;
    bus_b.data = 1'b0;
    bus_b.ack  = 1'b0;

    // d=0 flow, done hold, ack-cycle data ignored, mid-LOAD reset
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
    for (int i = 0; i < 9; i++)
      vq.push_back('{1'b0, 1'(i % 2), 1'b0, 1'b0, 1'b1, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    for (int i = 0; i < 5; i++)
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
    for (int i = 0; i < 3; i++)
      vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
    vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});

    for (int i = 0; i < vq.size(); i++) begin
      apply_stimulus(vq[i]);
      check_output($sformatf("vec%0d", i), vq[i].exp_counting, vq[i].exp_done, vq[i].exp_count);
    end
    reset = 1'b0;

    $display("[TB] sequence: d=5 profile");
    send_bits(16'b1101_0101, 8);
    run_profile(5, 1'b0);
    ack_pulse();

    $display("[TB] sequence: overlapping 11101, d=15");
    send_bits(16'b1_1101_1111, 9);
    run_profile(15, 1'b0);
    ack_pulse();

    $display("[TB] sequence: reset in 10th COUNT cycle");
    send_bits(16'b1101_0101, 8);
    for (int i = 0; i < 9; i++) step();
    check_output("before_reset", 1'b1, 1'b0, 4'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("after_reset", 1'b0, 1'b0, 4'd0);
    send_bits(16'b1101_0010, 8);
    run_profile(2, 1'b0);
    ack_pulse();

    $display("[TB] sequence: false start then disturbed count");
    send_bits(16'b1100_1101_0011, 12);
    run_profile(3, 1'b1);
    ack_pulse();

    $display("[TB] sequence: default TICKS, d=1");
    for (int i = 15; i >= 8; i--) begin
      bus_b.data = 1'(16'h00D1 >> (i - 8));
      step();
    end
    bus_b.data  = 1'b0;
    first_count = int'(bus_b.count);
    cycles = 0;
    ones   = 0;
    while (bus_b.counting === 1'b1 && cycles < 3000) begin
      if (bus_b.count == 4'd1) ones++;
      step();
      cycles++;
    end
    check_val("b_first_count", first_count, 1);
    check_val("b_counting_cycles", cycles, 2000);
    check_val("b_count1_cycles", ones, 1000);
    check_val("b_done", int'(bus_b.done), 1);
    bus_b.ack = 1'b1;
    step();
    bus_b.ack = 1'b0;
    check_val("b_ack_clear", int'(bus_b.done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/delay_timer_ctrl.md
DELAY_TIMER_CTRL -- requirements
Module: delay_timer_ctrl

Interface
REQ-001 Parameter: TICKS, default 1000, number of clock cycles per delay unit; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 data  input  1  serial bit stream; carries the start pattern, then the 4-bit delay MSB first.
REQ-005 ack  input  1  user acknowledge of timer expiry.
REQ-006 count  output  4  remaining whole delay units while counting.
REQ-007 counting  output  1  high while the timer runs.
REQ-008 done  output  1  high from timer expiry until ack is accepted.

Function
REQ-009 Controller SHALL integrate a pattern detector, a 4-bit delay shift register, a unit countdown and a sub-cycle tick counter; no external datapath is required.
REQ-010 States SHALL be SRCH, SRCH1, SRCH11, SRCH110, LOAD0, LOAD1, LOAD2, LOAD3, COUNT and WAIT.
REQ-011 Search transitions: SRCH: data=1->SRCH1, else SRCH; SRCH1: 1->SRCH11, 0->SRCH; SRCH11: 1->SRCH11, 0->SRCH110; SRCH110: 1->LOAD0, 0->SRCH.
REQ-012 Overlapping patterns SHALL be detected; e.g. 11101 starts the timer.
REQ-013 LOAD0..LOAD3 SHALL each shift data into the delay register LSB end, one bit per cycle, unconditionally, then advance; LOAD3->COUNT.
REQ-014 On entry to COUNT: count = captured delay d (0..15), tick counter = 0.
REQ-015 In COUNT the tick counter SHALL increment each cycle; when it reaches TICKS-1 it SHALL wrap to 0 and count SHALL decrement, unless count = 0.
REQ-016 When count = 0 and tick counter = TICKS-1, state SHALL go COUNT->WAIT; COUNT therefore lasts exactly (d+1)*TICKS cycles.
REQ-017 counting SHALL be 1 exactly in COUNT; done SHALL be 1 exactly in WAIT; both are Moore outputs.
REQ-018 count SHALL show the value of REQ-015 in COUNT and SHALL be 0 in every other state.
REQ-019 WAIT: ack=1->SRCH, else WAIT; data is ignored in WAIT and in the ack cycle.
REQ-020 ack SHALL be ignored in all states except WAIT; data SHALL be ignored in LOAD-excluded states COUNT and WAIT.
REQ-021 Pattern search SHALL restart in SRCH; bits preceding ack are never part of a new pattern.
REQ-022 Tick counter width SHALL be the minimum holding TICKS-1; no overflow past TICKS-1 is permitted.
REQ-023 Unreachable state encodings SHALL recover to SRCH on the next edge.

Reset
REQ-024 reset=1 at a rising edge SHALL force SRCH, delay register 0, tick counter 0, count 0, counting 0, done 0, regardless of the current state, including mid-LOAD and mid-COUNT.
REQ-025 reset SHALL take priority over ack and data in the same cycle.
REQ-026 After reset deasserts, the first data bit sampled SHALL be the first candidate pattern bit.

Verification (TICKS=4 unless noted)
REQ-027 data 1,1,0,1 then 0,1,0,1 (d=5) -> counting=1 for 24 cycles; count 5 for 4 cycles, then 4,3,2,1,0 four cycles each; then done=1.
REQ-028 Pattern then d=0 -> counting=1 exactly 4 cycles with count=0; done holds 10 cycles with ack=0; ack=1 one cycle -> done=0 next cycle, state SRCH.
REQ-029 data 1,1,1,0,1 then 1,1,1,1 -> timer starts (overlap); counting lasts 64 cycles; count starts at 15.
REQ-030 reset=1 in the 10th COUNT cycle -> next cycle counting=0, count=0, done=0; fresh pattern with d=2 -> 12-cycle count.
REQ-031 1,1,0,0,1,1,0,1 stream -> only final 1101 triggers LOAD; data toggled and ack pulsed during COUNT -> no effect on duration.
REQ-032 TICKS=1000 default, d=1 -> counting high exactly 2000 cycles, count 1 for first 1000.
